// File: rtl/fwd_ctrl_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller:
// mux select codes, scoreboard slot layout and the slot match rule.
package fwd_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [1:0] FWD_RET = 2'b11;

  // Slots carry register indices zero-extended to this width so the slot type
  // stays independent of the top-level RB parameter (RB must not exceed it).
  localparam int RB_MAX = 8;

  typedef struct packed {
    logic              v;
    logic [RB_MAX-1:0] rd;
    logic              we;
    logic              ld;
  } sb_slot_t;

  // x0 is hard-wired zero, so a write to it never forwards.
  function automatic logic slot_match(sb_slot_t s, logic [RB_MAX-1:0] r, logic used);
    return s.v & s.we & (s.rd == r) & (r != '0) & used;
  endfunction

endpackage

// File: rtl/fwd_pick.sv
// Per-operand forwarding selector: nearest in-flight producer wins.
module fwd_pick
  import fwd_ctrl_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic [RB_MAX-1:0] src_i,
  input  logic              used_i,
  input  sb_slot_t          ex_i,
  input  sb_slot_t          mem_i,
  input  sb_slot_t          wb_i,
  output logic [1:0]        sel_o,
  output logic              ex_hit_o
);

  logic mem_hit;
  logic wb_hit;

  assign ex_hit_o = slot_match(ex_i, src_i, used_i);
  assign mem_hit  = slot_match(mem_i, src_i, used_i);
  assign wb_hit   = slot_match(wb_i, src_i, used_i);

  // The WB slot is three ahead of the operand's own EX cycle; without the
  // retired latch a write-through regfile already returns the value.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_hit_o)     sel_o = FWD_MEM;
    else if (mem_hit) sel_o = FWD_WB;
    else if (wb_hit)  sel_o = WB_BYPASS ? FWD_RET : FWD_RF;
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for a 5-stage RV32I pipe.
// A three-slot scoreboard shadows EX/MEM/WB to drive registered EX mux selects.
module fwd_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int RB        = 5,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNTW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RB-1:0]   id_rs1,
  input  logic [RB-1:0]   id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RB-1:0]   id_rd,
  input  logic            id_we,
  input  logic            id_is_load,
  input  logic            flush,
  input  logic            hold,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            id_stall,
  output logic [CNTW-1:0] stall_cnt
);

  sb_slot_t ex_q, mem_q, wb_q;
  sb_slot_t ins_d;
  logic [1:0]      sel_a_q, sel_b_q;
  logic [1:0]      sel_a_d, sel_b_d;
  logic            ex_hit_a, ex_hit_b;
  logic [CNTW-1:0] stall_cnt_q;

  logic [RB_MAX-1:0] rs1_x, rs2_x, rd_x;
  assign rs1_x = RB_MAX'(id_rs1);
  assign rs2_x = RB_MAX'(id_rs2);
  assign rd_x  = RB_MAX'(id_rd);

  fwd_pick #(.WB_BYPASS(WB_BYPASS)) u_pick_a (
    .src_i(rs1_x), .used_i(id_rs1_used), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
    .sel_o(sel_a_d), .ex_hit_o(ex_hit_a)
  );

  fwd_pick #(.WB_BYPASS(WB_BYPASS)) u_pick_b (
    .src_i(rs2_x), .used_i(id_rs2_used), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
    .sel_o(sel_b_d), .ex_hit_o(ex_hit_b)
  );

  // Only a load sitting in EX is too late to forward; one bubble puts it in MEM.
  assign id_stall = id_valid & ~flush & ex_q.ld & (ex_hit_a | ex_hit_b);

  always_comb begin
    ins_d    = '0;
    ins_d.v  = id_valid & ~id_stall & ~flush;
    ins_d.rd = rd_x;
    ins_d.we = id_we;
    ins_d.ld = id_is_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      sel_a_q     <= FWD_RF;
      sel_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else if (!hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ins_d;
      if (id_stall || flush) begin
        sel_a_q <= FWD_RF;
        sel_b_q <= FWD_RF;
      end else begin
        sel_a_q <= sel_a_d;
        sel_b_q <= sel_b_d;
      end
      if (id_stall && (stall_cnt_q != {CNTW{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: two instances (retired bypass with a 16-bit
// counter, write-through regfile with a 2-bit counter) share one stimulus.
module tb_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic        id_we = 1'b0, id_is_load = 1'b0;
  logic        flush = 1'b0, hold = 1'b0;

  logic [1:0]  a1, b1, a0, b0;
  logic        st1, st0;
  logic [15:0] cnt1;
  logic [1:0]  cnt0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fwd_ctrl #(.RB(5), .WB_BYPASS(1'b1), .CNTW(16)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_we(id_we), .id_is_load(id_is_load), .flush(flush), .hold(hold),
    .fwd_a_sel(a1), .fwd_b_sel(b1), .id_stall(st1), .stall_cnt(cnt1)
  );

  fwd_ctrl #(.RB(5), .WB_BYPASS(1'b0), .CNTW(2)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_we(id_we), .id_is_load(id_is_load), .flush(flush), .hold(hold),
    .fwd_a_sel(a0), .fwd_b_sel(b0), .id_stall(st0), .stall_cnt(cnt0)
  );

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, act);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd = rd; id_we = we; id_is_load = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    #1;
    check("reset_a_sel", a1, 0);
    check("reset_b_sel", b1, 0);
    check("reset_stall", st1, 0);
    check("reset_cnt", cnt1, 0);
    @(negedge clk);
    rst = 1'b0;
    drain();

    // add x5,x1,x2 ; sub x6,x5,x3
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
    tick();
    set_id(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0);
    check("raw1_stall", st1, 0);
    tick();
    check("raw1_a_sel", a1, 1);
    check("raw1_b_sel", b1, 0);
    drain();

    // lw x7,0(x1) ; add x8,x7,x7
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1);
    tick();
    set_id(1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0);
    check("lu_stall", st1, 1);
    tick();
    check("lu_bubble_a", a1, 0);
    check("lu_bubble_b", b1, 0);
    check("lu_cnt", cnt1, 1);
    check("lu_stall_1cyc", st1, 0);
    tick();
    check("lu_a_sel", a1, 2);
    check("lu_b_sel", b1, 2);
    check("lu_cnt_hold", cnt1, 1);
    drain();

    // writer x9, two unrelated, reader x9
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0);  tick();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd10, 1, 0); tick();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd11, 1, 0); tick();
    set_id(1, 5'd9, 5'd9, 1, 1, 5'd12, 1, 0); tick();
    check("ret_a_bypass", a1, 3);
    check("ret_b_bypass", b1, 3);
    check("ret_a_wthru", a0, 0);
    check("ret_b_wthru", b0, 0);
    drain();

    // addi x0,x0,1 ; add x3,x0,x0
    set_id(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0);
    tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd3, 1, 0);
    check("x0_stall", st1, 0);
    tick();
    check("x0_a_sel", a1, 0);
    check("x0_b_sel", b1, 0);
    drain();

    // x12 written two and one ahead: nearest wins
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd12, 1, 0); tick();
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd12, 1, 0); tick();
    set_id(1, 5'd12, 5'd12, 1, 1, 5'd4, 1, 0); tick();
    check("near_a_sel", a1, 1);
    check("near_b_sel", b1, 1);
    drain();

    // load-use with flush in the same cycle
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1);
    tick();
    set_id(1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0);
    flush = 1'b1;
    #1;
    check("flush_stall", st1, 0);
    tick();
    flush = 1'b0;
    check("flush_a_sel", a1, 0);
    check("flush_cnt", cnt1, 1);
    drain();

    // hold for 3 cycles with a pending reader of x13
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd13, 1, 0);  tick();
    set_id(1, 5'd13, 5'd0, 1, 0, 5'd15, 1, 0); tick();
    check("hold_pre_a", a1, 1);
    set_id(1, 5'd13, 5'd0, 1, 0, 5'd16, 1, 0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_a_%0d", i), a1, 1);
    end
    hold = 1'b0;
    tick();
    check("hold_post_a", a1, 2);
    drain();

    // hold during a load-use stall: stall visible, count frozen
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1);
    tick();
    set_id(1, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0);
    hold = 1'b1;
    #1;
    check("hstall_stall", st1, 1);
    tick();
    check("hstall_cnt_frz", cnt1, 1);
    hold = 1'b0;
    tick();
    check("hstall_cnt", cnt1, 2);
    tick();
    check("hstall_a_sel", a1, 2);
    drain();

    // async reset in the middle of a stall
    set_id(1, 5'd0, 5'd0, 0, 0, 5'd1, 1, 0); tick();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1); tick();
    check("rst_pre_a", a1, 1);
    set_id(1, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0);
    check("rst_pre_stall", st1, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_a", a1, 0);
    check("rst_async_stall", st1, 0);
    check("rst_async_cnt", cnt1, 0);
    rst = 1'b0;
    drain();

    // saturation of the 2-bit counter
    for (int i = 1; i <= 4; i++) begin
      set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1);
      tick();
      set_id(1, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0);
      check($sformatf("sat_stall_%0d", i), st0, 1);
      tick();
      check($sformatf("sat_cnt0_%0d", i), cnt0, (i > 3) ? 3 : i);
      check($sformatf("sat_cnt1_%0d", i), cnt1, i);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
